// File: rtl/fix_msg_link_buffer.sv
// Store-and-forward FIX message link: captures one engine's outbound words, commits whole
// messages, then replays each to the peer with a new-message pulse and a ready/valid stream.
module fix_msg_link_buffer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 512,
    parameter int MAX_MSGS   = 4,
    parameter int SKIP_BYTES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          in_write_i,
    input  logic [DATA_W-1:0]             in_data_i,
    input  logic                          in_end_i,
    output logic                          in_full_o,
    output logic                          out_new_msg_o,
    output logic                          out_valid_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic                          out_last_o,
    input  logic                          out_ready_i,
    output logic [$clog2(MAX_MSGS+1)-1:0] msg_count_o,
    output logic [7:0]                    drop_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_MSGS);
    localparam int CW = $clog2(MAX_MSGS + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ANNOUNCE = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem_r     [DEPTH];
    logic [PW-1:0]     len_mem_r [MAX_MSGS];

    state_t            state_r;
    logic [PW-1:0]     wr_ptr_r, commit_ptr_r, free_ptr_r, rd_ptr_r, remain_r;
    logic [LW-1:0]     len_wr_r, len_rd_r;
    logic [CW-1:0]     msg_count_r;
    logic [7:0]        drop_count_r;
    logic [3:0]        skip_cnt_r;
    logic              ovf_r, full_r, new_msg_r, valid_r, last_r;
    logic [DATA_W-1:0] data_r;

    logic              skip_s, store_s, ovf_hit_s, end_s, commit_s, drop_s, release_s;
    logic [PW-1:0]     wr_inc_s, len_s, wr_next_s, commit_next_s, free_next_s, used_next_s;

    // Inbound word classification and the next values of the shared pointers.
    always_comb begin
        skip_s        = (skip_cnt_r != 4'(SKIP_BYTES));
        store_s       = in_write_i && !skip_s && !full_r && !ovf_r;
        ovf_hit_s     = in_write_i && !skip_s && full_r;
        end_s         = in_write_i && in_end_i;
        wr_inc_s      = store_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        len_s         = wr_inc_s - commit_ptr_r;
        // The slot limit counts the message currently streaming, not just queued lengths.
        commit_s      = end_s && !ovf_r && !ovf_hit_s && (len_s != {PW{1'b0}})
                        && (msg_count_r < CW'(MAX_MSGS));
        drop_s        = end_s && !commit_s;
        release_s     = (state_r == ST_STREAM) && out_ready_i && last_r;
        wr_next_s     = drop_s ? commit_ptr_r : wr_inc_s;
        commit_next_s = commit_s ? wr_inc_s : commit_ptr_r;
        free_next_s   = release_s ? rd_ptr_r : free_ptr_r;
        used_next_s   = wr_next_s - free_next_s;
    end

    // Data and length storage; plain RAM whose contents need no reset.
    always_ff @(posedge clk) begin
        if (store_s) mem_r[wr_ptr_r[AW-1:0]] <= in_data_i;
        if (commit_s) len_mem_r[len_wr_r] <= len_s;
    end

    // Write-side bookkeeping: pointers, skip/overflow tracking, counters and full flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            commit_ptr_r <= {PW{1'b0}};
            free_ptr_r   <= {PW{1'b0}};
            full_r       <= 1'b0;
            len_wr_r     <= {LW{1'b0}};
            skip_cnt_r   <= 4'd0;
            ovf_r        <= 1'b0;
            msg_count_r  <= {CW{1'b0}};
            drop_count_r <= 8'd0;
        end else if (flush_i) begin
            wr_ptr_r     <= {PW{1'b0}};
            commit_ptr_r <= {PW{1'b0}};
            free_ptr_r   <= {PW{1'b0}};
            full_r       <= 1'b0;
            len_wr_r     <= {LW{1'b0}};
            skip_cnt_r   <= 4'd0;
            ovf_r        <= 1'b0;
            msg_count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r     <= wr_next_s;
            commit_ptr_r <= commit_next_s;
            free_ptr_r   <= free_next_s;
            full_r       <= (used_next_s == PW'(DEPTH));
            if (commit_s) len_wr_r <= len_wr_r + LW'(1);
            if (end_s) begin
                skip_cnt_r <= 4'd0;
                ovf_r      <= 1'b0;
            end else begin
                if (in_write_i && skip_s) skip_cnt_r <= skip_cnt_r + 4'd1;
                if (ovf_hit_s) ovf_r <= 1'b1;
            end
            case ({commit_s, release_s})
                2'b10:   msg_count_r <= msg_count_r + CW'(1);
                2'b01:   msg_count_r <= msg_count_r - CW'(1);
                default: msg_count_r <= msg_count_r;
            endcase
            if (drop_s && (drop_count_r != 8'hFF)) drop_count_r <= drop_count_r + 8'd1;
        end
    end

    // Read-side sequencer: announce a message, then stream it with one RAM read per handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            rd_ptr_r  <= {PW{1'b0}};
            remain_r  <= {PW{1'b0}};
            len_rd_r  <= {LW{1'b0}};
            new_msg_r <= 1'b0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            data_r    <= {DATA_W{1'b0}};
        end else if (flush_i) begin
            state_r   <= ST_IDLE;
            rd_ptr_r  <= {PW{1'b0}};
            remain_r  <= {PW{1'b0}};
            len_rd_r  <= {LW{1'b0}};
            new_msg_r <= 1'b0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            data_r    <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (msg_count_r != {CW{1'b0}}) begin
                        state_r   <= ST_ANNOUNCE;
                        new_msg_r <= 1'b1;
                    end
                end
                ST_ANNOUNCE: begin
                    new_msg_r <= 1'b0;
                    valid_r   <= 1'b1;
                    data_r    <= mem_r[rd_ptr_r[AW-1:0]];
                    last_r    <= (len_mem_r[len_rd_r] == PW'(1));
                    remain_r  <= len_mem_r[len_rd_r];
                    rd_ptr_r  <= rd_ptr_r + PW'(1);
                    len_rd_r  <= len_rd_r + LW'(1);
                    state_r   <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (out_ready_i) begin
                        if (last_r) begin
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            // remain_r counts the word on the bus, so 2 means the next is final.
                            data_r   <= mem_r[rd_ptr_r[AW-1:0]];
                            last_r   <= (remain_r == PW'(2));
                            remain_r <= remain_r - PW'(1);
                            rd_ptr_r <= rd_ptr_r + PW'(1);
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    new_msg_r <= 1'b0;
                    valid_r   <= 1'b0;
                    last_r    <= 1'b0;
                end
            endcase
        end
    end

    assign in_full_o     = full_r;
    assign out_new_msg_o = new_msg_r;
    assign out_valid_o   = valid_r;
    assign out_data_o    = data_r;
    assign out_last_o    = last_r;
    assign msg_count_o   = msg_count_r;
    assign drop_count_o  = drop_count_r;

endmodule

// File: tb/tb_fix_msg_link_buffer.sv
// Bench for fix_msg_link_buffer: directed vector table, corner-case sequences and a randomized
// run checked against a queue-based message model.
module tb_fix_msg_link_buffer;
    localparam int DEPTH = 8;
    localparam int MAXM  = 4;
    localparam int SKIP  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush_i = 1'b0;
    logic       in_write_i = 1'b0;
    logic [7:0] in_data_i = 8'd0;
    logic       in_end_i = 1'b0;
    logic       in_full_o;
    logic       out_new_msg_o;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic       out_last_o;
    logic       out_ready_i = 1'b1;
    logic [2:0] msg_count_o;
    logic [7:0] drop_count_o;

    int tests = 0;
    int failed = 0;

    logic [7:0] exp_bytes[$];
    logic [7:0] pend_bytes[$];
    int         pend_len[$];
    logic [7:0] inprog[$];
    int         nacc, pos, mdrop;
    bit         movf;

    typedef struct packed {
        logic       wr;
        logic [7:0] din;
        logic       endm;
        logic       rdy;
        logic       new_m;
        logic       vld;
        logic [7:0] dout;
        logic       lst;
        logic [2:0] cnt;
    } vec_t;
    vec_t vecs[$];

    fix_msg_link_buffer #(.DATA_W(8), .DEPTH(DEPTH), .MAX_MSGS(MAXM), .SKIP_BYTES(SKIP)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_write_i(in_write_i), .in_data_i(in_data_i),
        .in_end_i(in_end_i), .in_full_o(in_full_o), .out_new_msg_o(out_new_msg_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .out_ready_i(out_ready_i), .msg_count_o(msg_count_o), .drop_count_o(drop_count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_write_i = 1'b0; in_data_i = 8'd0; in_end_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [7:0] d, input logic e);
        in_write_i = 1'b1; in_data_i = d; in_end_i = e;
        tick();
        in_write_i = 1'b0; in_end_i = 1'b0;
    endtask

    task automatic wait_new(input string name);
        int t = 0;
        while (!out_new_msg_o && t < 20) begin tick(); t++; end
        check(name, out_new_msg_o, 1'b1);
        tick();
    endtask

    task automatic expect_msg(input int n, input bit chk_new);
        int t;
        logic [7:0] w;
        if (chk_new) wait_new("msg_new");
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!out_valid_o && t < 20) begin tick(); t++; end
            w = exp_bytes.pop_front();
            check("msg_valid", out_valid_o, 1'b1);
            check("msg_data", out_data_o, w);
            check("msg_last", out_last_o, k == n - 1);
            tick();
        end
    endtask

    // One cycle of random traffic: compare outputs with the model, then apply the next edge's rules.
    task automatic rand_step(input logic w, input logic [7:0] d, input logic e, input logic r);
        logic [7:0] tmp;
        int occ;
        occ = pend_bytes.size() + inprog.size();
        check("rnd_count", msg_count_o, pend_len.size());
        check("rnd_drop", drop_count_o, mdrop);
        check("rnd_full", in_full_o, occ == DEPTH);
        if (out_valid_o) begin
            check("rnd_valid_has_pending", pend_len.size() != 0, 1'b1);
            if (pend_len.size() != 0) begin
                check("rnd_data", out_data_o, pend_bytes[pos]);
                check("rnd_last", out_last_o, pos == pend_len[0] - 1);
            end
        end
        in_write_i = w; in_data_i = d; in_end_i = e; out_ready_i = r;
        if (w) begin
            if (nacc < SKIP) nacc++;
            else if (occ == DEPTH) movf = 1'b1;
            else if (!movf) inprog.push_back(d);
            if (e) begin
                if (!movf && inprog.size() > 0 && pend_len.size() < MAXM) begin
                    foreach (inprog[k]) pend_bytes.push_back(inprog[k]);
                    pend_len.push_back(inprog.size());
                end else if (mdrop < 255) begin
                    mdrop++;
                end
                inprog.delete();
                nacc = 0;
                movf = 1'b0;
            end
        end
        if (out_valid_o && r && pend_len.size() != 0) begin
            if (pos == pend_len[0] - 1) begin
                for (int k = 0; k < pend_len[0]; k++) tmp = pend_bytes.pop_front();
                occ = pend_len.pop_front();
                pos = 0;
            end else begin
                pos++;
            end
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic w, e, r;

        // Reset state
        tick();
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_new", out_new_msg_o, 1'b0);
        check("rst_last", out_last_o, 1'b0);
        check("rst_count", msg_count_o, 3'd0);
        check("rst_drop", drop_count_o, 8'd0);
        check("rst_full", in_full_o, 1'b0);
        do_reset();

        // Vector table: basic delivery, then the same message with ready low for 3 cycles on 42
        //                  wr    din    end   rdy   new   vld   dout   lst   cnt
        vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h43, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h43, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h43, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h43, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        foreach (vecs[i]) begin
            in_write_i = vecs[i].wr; in_data_i = vecs[i].din;
            in_end_i = vecs[i].endm; out_ready_i = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_new", i), out_new_msg_o, vecs[i].new_m);
            check($sformatf("vec%0d_valid", i), out_valid_o, vecs[i].vld);
            check($sformatf("vec%0d_last", i), out_last_o, vecs[i].lst);
            check($sformatf("vec%0d_count", i), msg_count_o, vecs[i].cnt);
            if (vecs[i].vld) check($sformatf("vec%0d_data", i), out_data_o, vecs[i].dout);
        end
        in_write_i = 1'b0; in_end_i = 1'b0;

        // Oversized message overflows the 8-entry buffer and is dropped
        do_reset();
        send_word(8'hA0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            send_word(8'(16 + i), i == 10);
            if (i == 7) check("ovf_full", in_full_o, 1'b1);
        end
        check("ovf_drop", drop_count_o, 8'd1);
        check("ovf_count", msg_count_o, 3'd0);
        check("ovf_full_after", in_full_o, 1'b0);
        exp_bytes = '{8'h51, 8'h52, 8'h53};
        send_word(8'hA1, 1'b0); send_word(8'h51, 1'b0); send_word(8'h52, 1'b0); send_word(8'h53, 1'b1);
        expect_msg(3, 1'b1);
        check("ovf_next_count", msg_count_o, 3'd0);

        // Five messages against four slots with the peer stalled
        do_reset();
        out_ready_i = 1'b0;
        for (int m = 0; m < 5; m++) begin
            send_word(8'(8'hC0 + m), 1'b0);
            send_word(8'(8'h20 + 2 * m), 1'b0);
            send_word(8'(8'h21 + 2 * m), 1'b1);
            if (m < 4) begin
                exp_bytes.push_back(8'(8'h20 + 2 * m));
                exp_bytes.push_back(8'(8'h21 + 2 * m));
            end
        end
        check("slots_count", msg_count_o, 3'd4);
        check("slots_drop", drop_count_o, 8'd1);
        check("slots_full", in_full_o, 1'b1);
        out_ready_i = 1'b1;
        expect_msg(2, 1'b0);
        for (int m = 1; m < 4; m++) expect_msg(2, 1'b1);
        check("slots_count_end", msg_count_o, 3'd0);

        // Message no longer than the header is dropped without an announcement
        do_reset();
        send_word(8'h77, 1'b1);
        check("short_drop", drop_count_o, 8'd1);
        seen = 1'b0;
        repeat (6) begin
            if (out_new_msg_o || out_valid_o) seen = 1'b1;
            tick();
        end
        check("short_no_announce", seen, 1'b0);

        // Flush mid-stream and mid-inbound, then a clean message
        do_reset();
        send_word(8'hE0, 1'b0); send_word(8'h61, 1'b0); send_word(8'h62, 1'b0); send_word(8'h63, 1'b1);
        wait_new("flush_new");
        check("flush_streaming", out_valid_o, 1'b1);
        check("flush_first", out_data_o, 8'h61);
        out_ready_i = 1'b0;
        send_word(8'hE1, 1'b0); send_word(8'h71, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_valid", out_valid_o, 1'b0);
        check("flush_new_low", out_new_msg_o, 1'b0);
        check("flush_count", msg_count_o, 3'd0);
        check("flush_drop_kept", drop_count_o, 8'd0);
        seen = 1'b0;
        repeat (4) begin
            if (out_new_msg_o || out_valid_o) seen = 1'b1;
            tick();
        end
        check("flush_no_replay", seen, 1'b0);
        out_ready_i = 1'b1;
        exp_bytes = '{8'h81, 8'h82};
        send_word(8'hE2, 1'b0); send_word(8'h81, 1'b0); send_word(8'h82, 1'b1);
        expect_msg(2, 1'b1);
        check("flush_clean_count", msg_count_o, 3'd0);

        // Asynchronous reset in the middle of a stream
        send_word(8'h55, 1'b1);
        check("rstmid_drop_before", drop_count_o, 8'd1);
        send_word(8'hF0, 1'b0); send_word(8'h91, 1'b0); send_word(8'h92, 1'b0); send_word(8'h93, 1'b1);
        wait_new("rstmid_new");
        out_ready_i = 1'b0;
        check("rstmid_streaming", out_valid_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_valid", out_valid_o, 1'b0);
        check("rstmid_data", out_data_o, 8'h00);
        check("rstmid_last", out_last_o, 1'b0);
        check("rstmid_new_low", out_new_msg_o, 1'b0);
        check("rstmid_count", msg_count_o, 3'd0);
        check("rstmid_drop", drop_count_o, 8'd0);
        #3 rst = 1'b1;
        out_ready_i = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (out_new_msg_o || out_valid_o) seen = 1'b1;
        end
        check("rstmid_no_replay", seen, 1'b0);

        // Randomized traffic against the message model
        do_reset();
        pend_bytes.delete(); pend_len.delete(); inprog.delete();
        nacc = 0; pos = 0; mdrop = 0; movf = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            w = ($urandom_range(0, 9) < 6);
            e = w && ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 9) < 7);
            rand_step(w, 8'($urandom), e, r);
        end
        for (int c = 0; c < 300 && (pend_len.size() != 0 || out_valid_o); c++)
            rand_step(1'b0, 8'h00, 1'b0, 1'b1);
        check("rnd_drained", pend_len.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
